// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide scheduler slice.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESP   = 3'd4,
    ST_ABORT  = 3'd5
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int unsigned DEF_TIMEOUT = 48;
  localparam int unsigned DEF_SETTLE  = 2;
  localparam int unsigned DEF_RST_CYC = 2;

  localparam int unsigned RES_W = 64;
  localparam int unsigned OPA_W = 32;
  localparam int unsigned OPB_W = 64;

  // One operation as handed to the shared unit
  typedef struct packed {
    logic             op;
    logic [OPA_W-1:0] opa;
    logic [OPB_W-1:0] opb;
  } mreq_t;

endpackage

// File: rtl/muldiv_sched_rr_arb2.sv
// Two-input round-robin arbiter; last_grant moves only when a grant is accepted.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant_c
);

  logic last_grant;

  // On a tie the requester that did not win last time goes first
  always_comb begin
    grant_c = req;
    if (&req) grant_c = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       last_grant <= 1'b1;
    else if (accept) last_grant <= grant_c[1];
  end

endmodule

// File: rtl/muldiv_sched.sv
// Shares one signed multiply/divide unit between two requesters: arbitrate,
// issue, wait for a fresh valid, settle, respond; a watchdog aborts hung ops.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned SETTLE  = DEF_SETTLE,
  parameter int unsigned RST_CYC = DEF_RST_CYC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [OPA_W-1:0] req0_opa,
  input  logic [OPB_W-1:0] req0_opb,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [OPA_W-1:0] req1_opa,
  input  logic [OPB_W-1:0] req1_opb,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [RES_W-1:0] rsp_result,
  output logic             rsp_error,
  output logic             mu_start,
  output logic             mu_muordi,
  output logic [OPA_W-1:0] mu_opera1,
  output logic [OPB_W-1:0] mu_opera2,
  output logic             mu_reset,
  input  logic             mu_valid,
  input  logic [RES_W-1:0] mu_result
);

  localparam int unsigned TMR_MAX   = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
  localparam int unsigned SETTLE_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int unsigned SET_W     = (SETTLE_M1 > 1) ? $clog2(SETTLE_M1 + 1) : 1;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               seen_low_q, seen_low_d;
  logic               owner_q;
  mreq_t              op_q;
  mreq_t              req0_c, req1_c;
  logic [1:0]         grant_c;
  logic               accept_c;
  logic               capture_c;
  logic               err_fire_c;
  logic               rsp_fire_c;
  logic               mu_start_d;
  logic               mu_reset_d;

  assign req0_c = '{op: req0_op, opa: req0_opa, opb: req0_opb};
  assign req1_c = '{op: req1_op, opa: req1_opa, opb: req1_opb};

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({req1_valid, req0_valid}),
    .accept  (accept_c),
    .grant_c (grant_c)
  );

  // Requests are only offered a handshake while idle
  assign accept_c   = (state_q == ST_IDLE) && (|grant_c);
  assign req0_ready = (state_q == ST_IDLE) && grant_c[0];
  assign req1_ready = (state_q == ST_IDLE) && grant_c[1];

  assign mu_muordi = op_q.op;
  assign mu_opera1 = op_q.opa;
  assign mu_opera2 = op_q.opb;

  // Next state; the timer is shared between the watchdog and the abort hold
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    settle_d   = settle_q;
    seen_low_d = seen_low_q;
    capture_c  = 1'b0;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_ISSUE;
      ST_ISSUE: begin
        seen_low_d = 1'b0;
        timer_d    = TMR_W'(TIMEOUT);
        state_d    = ST_WAIT;
      end
      ST_WAIT, ST_SETTLE: begin
        if (timer_q == '0) begin
          state_d = ST_ABORT;
          timer_d = TMR_W'(RST_CYC);
        end else begin
          timer_d = timer_q - TMR_W'(1);
          if (state_q == ST_WAIT) begin
            // A valid left over from the last op is ignored until seen low
            if (!mu_valid) begin
              seen_low_d = 1'b1;
            end else if (seen_low_q) begin
              state_d  = ST_SETTLE;
              settle_d = SET_W'(SETTLE_M1);
            end
          end else if (settle_q == '0) begin
            capture_c = 1'b1;
            state_d   = ST_RESP;
          end else begin
            settle_d = settle_q - SET_W'(1);
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ABORT: begin
        if (timer_q == '0) state_d = ST_IDLE;
        else               timer_d = timer_q - TMR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    err_fire_c = (state_d == ST_ABORT) && (timer_d == '0);
    rsp_fire_c = (state_d == ST_RESP) || err_fire_c;
    mu_start_d = (state_d == ST_ISSUE);
    mu_reset_d = (state_d == ST_ABORT) && (timer_d != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      settle_q   <= '0;
      seen_low_q <= 1'b0;
      owner_q    <= 1'b0;
      op_q       <= '{op: OP_MUL, opa: '0, opb: '0};
      mu_start   <= 1'b0;
      mu_reset   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_result <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      settle_q   <= settle_d;
      seen_low_q <= seen_low_d;
      if (accept_c) begin
        op_q    <= grant_c[1] ? req1_c : req0_c;
        owner_q <= grant_c[1];
      end
      mu_start   <= mu_start_d;
      mu_reset   <= mu_reset_d;
      rsp0_valid <= rsp_fire_c && !owner_q;
      rsp1_valid <= rsp_fire_c && owner_q;
      rsp_error  <= err_fire_c;
      if (capture_c)       rsp_result <= mu_result;
      else if (err_fire_c) rsp_result <= '0;
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with a behavioural model of the shared unit.
module tb_muldiv_sched;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 35;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req0_op = 1'b0;
  logic [31:0] req0_opa = '0;
  logic [63:0] req0_opb = '0;
  logic        req1_valid = 1'b0, req1_op = 1'b0;
  logic [31:0] req1_opa = '0;
  logic [63:0] req1_opb = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp_error;
  logic [63:0] rsp_result;
  logic        mu_start, mu_muordi, mu_reset;
  logic [31:0] mu_opera1;
  logic [63:0] mu_opera2;
  logic        mu_valid;
  logic [63:0] mu_result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_start = 0;
  int n_rsp = 0;
  int clr_dly = 0;

  muldiv_sched dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_opa(req0_opa), .req0_opb(req0_opb),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_opa(req1_opa), .req1_opb(req1_opb),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .mu_start(mu_start), .mu_muordi(mu_muordi), .mu_opera1(mu_opera1),
    .mu_opera2(mu_opera2), .mu_reset(mu_reset),
    .mu_valid(mu_valid), .mu_result(mu_result)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mu_start) n_start <= n_start + 1;
    if (rsp0_valid || rsp1_valid) n_rsp <= n_rsp + 1;
  end

  // Unit model: valid stays high after a result until clr_dly cycles into the
  // next op; divides never complete; product uses the operands live at completion.
  logic mdl_busy, mdl_div;
  int   mdl_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mu_valid <= 1'b0; mu_result <= '0; mdl_busy <= 1'b0; mdl_div <= 1'b0; mdl_cnt <= 0;
    end else if (mu_reset) begin
      mu_valid <= 1'b0; mdl_busy <= 1'b0;
    end else if (mu_start) begin
      mdl_busy <= 1'b1; mdl_cnt <= 0; mdl_div <= mu_muordi;
    end else if (mdl_busy) begin
      mdl_cnt <= mdl_cnt + 1;
      if (mdl_cnt == clr_dly) mu_valid <= 1'b0;
      if (!mdl_div && mdl_cnt == MUL_LAT) begin
        mu_valid  <= 1'b1;
        mu_result <= longint'($signed(mu_opera1)) * longint'($signed(mu_opera2));
        mdl_busy  <= 1'b0;
      end
    end
  end

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Present a request and hold it until accepted; acc is the ISSUE cycle (-1 if never)
  task automatic request(input bit id, input logic op, input logic [31:0] a,
                         input logic [63:0] b, output int acc);
    acc = -1;
    if (!id) begin req0_op = op; req0_opa = a; req0_opb = b; req0_valid = 1'b1; end
    else     begin req1_op = op; req1_opa = a; req1_opb = b; req1_valid = 1'b1; end
    for (int i = 0; i < 200; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        @(negedge clock);
        acc = cyc;
        break;
      end
      @(negedge clock);
    end
    if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Wait for a response pulse; reports what was seen, compares nothing
  task automatic wait_rsp(output int rcyc, output logic g0, output logic g1,
                          output logic err, output logic [63:0] res, output int rise,
                          output int nrst, output bit moved);
    logic        pv;
    logic [31:0] a0;
    rcyc = -1; g0 = 1'b0; g1 = 1'b0; err = 1'b0; res = '0; rise = -1; nrst = 0; moved = 1'b0;
    pv = mu_valid; a0 = mu_opera1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (mu_valid && !pv) rise = cyc;
      pv = mu_valid;
      if (mu_reset) nrst++;
      if (mu_opera1 !== a0) moved = 1'b1;
      if (rsp0_valid || rsp1_valid) begin
        g0 = rsp0_valid; g1 = rsp1_valid; err = rsp_error; res = rsp_result; rcyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({mu_start, mu_reset, rsp0_valid, rsp1_valid, rsp_error, mu_muordi} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {mu_start, mu_reset, rsp0_valid, rsp1_valid, rsp_error, mu_muordi});
    end
    checks++;
    if ({rsp_result, mu_opera2, mu_opera1} !== 160'd0) begin
      failures++;
      $display("FAIL reset_data result=%h opera2=%h opera1=%h want 0", rsp_result, mu_opera2, mu_opera1);
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_mul();
    int acc, rcyc, rise, nrst, s0;
    logic g0, g1, err;
    logic [63:0] res;
    bit moved;
    s0 = n_start;
    request(1'b0, OP_MUL, 32'hFFFF_FFFD, 64'd7, acc);
    wait_rsp(rcyc, g0, g1, err, res, rise, nrst, moved);
    checks++;
    if ({g0, g1, err} !== 3'b100) begin
      failures++; $display("FAIL mul_rsp g0/g1/err=%b want=100", {g0, g1, err});
    end
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      failures++; $display("FAIL mul_result got=%h want=ffffffffffffffeb", res);
    end
    checks++;
    if (n_start - s0 !== 1) begin
      failures++; $display("FAIL mul_start_pulses got=%0d want=1", n_start - s0);
    end
    checks++;
    if (rcyc - rise !== 3) begin
      failures++; $display("FAIL mul_settle_latency got=%0d want=3", rcyc - rise);
    end
    checks++;
    if (rcyc - acc !== MUL_LAT + 5) begin
      failures++; $display("FAIL mul_total_latency got=%0d want=%0d", rcyc - acc, MUL_LAT + 5);
    end
  endtask

  task automatic test_tie();
    int acc, rcyc, rise, nrst;
    logic g0, g1, err;
    logic [63:0] res;
    bit moved;
    do_reset();
    req0_op = OP_MUL; req0_opa = 32'd5; req0_opb = 64'd6;
    req1_op = OP_MUL; req1_opa = 32'd2; req1_opb = 64'd9;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL tie_first_grant got=%b want=10", {req0_ready, req1_ready});
    end
    request(1'b0, OP_MUL, 32'd5, 64'd6, acc);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL tie_busy_ready got=%b want=00", {req0_ready, req1_ready});
    end
    wait_rsp(rcyc, g0, g1, err, res, rise, nrst, moved);
    checks++;
    if ({g0, g1, err, res} !== {3'b100, 64'd30}) begin
      failures++; $display("FAIL tie_rsp0 g0/g1/err=%b result=%0d want=100/30", {g0, g1, err}, res);
    end
    // req0 comes straight back while req1 is still waiting
    req0_opa = 32'd3; req0_opb = 64'd4; req0_valid = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++; $display("FAIL tie_second_grant got=%b want=01", {req0_ready, req1_ready});
    end
    request(1'b1, OP_MUL, 32'd2, 64'd9, acc);
    wait_rsp(rcyc, g0, g1, err, res, rise, nrst, moved);
    checks++;
    if ({g0, g1, err, res} !== {3'b010, 64'd18}) begin
      failures++; $display("FAIL tie_rsp1 g0/g1/err=%b result=%0d want=010/18", {g0, g1, err}, res);
    end
    checks++;
    if (rcyc - acc !== MUL_LAT + 5) begin
      failures++; $display("FAIL tie_rsp1_latency got=%0d want=%0d", rcyc - acc, MUL_LAT + 5);
    end
    request(1'b0, OP_MUL, 32'd3, 64'd4, acc);
    wait_rsp(rcyc, g0, g1, err, res, rise, nrst, moved);
    checks++;
    if ({g0, g1, err, res} !== {3'b100, 64'd12}) begin
      failures++; $display("FAIL tie_rsp0_again g0/g1/err=%b result=%0d want=100/12", {g0, g1, err}, res);
    end
  endtask

  task automatic test_div_timeout();
    int acc, rcyc, rise, nrst;
    logic g0, g1, err;
    logic [63:0] res;
    bit moved;
    request(1'b1, OP_DIV, 32'd10, 64'd3, acc);
    wait_rsp(rcyc, g0, g1, err, res, rise, nrst, moved);
    checks++;
    if ({g0, g1, err} !== 3'b011) begin
      failures++; $display("FAIL div_rsp g0/g1/err=%b want=011", {g0, g1, err});
    end
    checks++;
    if (res !== 64'd0) begin
      failures++; $display("FAIL div_result got=%h want=0", res);
    end
    checks++;
    if (nrst !== 2) begin
      failures++; $display("FAIL div_mu_reset_cycles got=%0d want=2", nrst);
    end
    checks++;
    if (rcyc - acc !== 1 + 48 + 2 + 1) begin
      failures++; $display("FAIL div_timeout_latency got=%0d want=52", rcyc - acc);
    end
  endtask

  task automatic test_stale_valid();
    int acc, rcyc, rise, nrst;
    logic g0, g1, err;
    logic [63:0] res;
    bit moved;
    request(1'b0, OP_MUL, 32'd2, 64'd3, acc);
    wait_rsp(rcyc, g0, g1, err, res, rise, nrst, moved);
    checks++;
    if ({g0, err, res} !== {2'b10, 64'd6}) begin
      failures++; $display("FAIL stale_prep g0/err=%b result=%0d want=10/6", {g0, err}, res);
    end
    clr_dly = 4;
    request(1'b0, OP_MUL, 32'd100, 64'd100, acc);
    wait_rsp(rcyc, g0, g1, err, res, rise, nrst, moved);
    clr_dly = 0;
    checks++;
    if ({g0, g1, err, res} !== {3'b100, 64'd10000}) begin
      failures++; $display("FAIL stale_result g0/g1/err=%b result=%0d want=100/10000", {g0, g1, err}, res);
    end
    checks++;
    if (rcyc - acc !== MUL_LAT + 5) begin
      failures++; $display("FAIL stale_latency got=%0d want=%0d", rcyc - acc, MUL_LAT + 5);
    end
  endtask

  task automatic test_reset_mid_op();
    int acc, rcyc, rise, nrst, s0;
    logic g0, g1, err;
    logic [63:0] res;
    bit moved;
    request(1'b0, OP_MUL, 32'd7, 64'd8, acc);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({mu_start, mu_reset, rsp0_valid, rsp1_valid, rsp_error, mu_muordi} !== 6'b0) begin
      failures++;
      $display("FAIL midrst_ctrl got=%b want=000000",
               {mu_start, mu_reset, rsp0_valid, rsp1_valid, rsp_error, mu_muordi});
    end
    checks++;
    if ({rsp_result, mu_opera2, mu_opera1} !== 160'd0) begin
      failures++;
      $display("FAIL midrst_data result=%h opera2=%h opera1=%h want 0", rsp_result, mu_opera2, mu_opera1);
    end
    @(negedge clock);
    reset = 1'b0;
    s0 = n_rsp;
    repeat (60) @(negedge clock);
    checks++;
    if (n_rsp - s0 !== 0) begin
      failures++; $display("FAIL midrst_no_rsp got=%0d pulses want=0", n_rsp - s0);
    end
    request(1'b0, OP_MUL, 32'hFFFF_FFFC, 64'd5, acc);
    wait_rsp(rcyc, g0, g1, err, res, rise, nrst, moved);
    checks++;
    if ({g0, g1, err, res} !== {3'b100, 64'hFFFF_FFFF_FFFF_FFEC}) begin
      failures++; $display("FAIL midrst_after g0/g1/err=%b result=%h want=100/ffffffffffffffec", {g0, g1, err}, res);
    end
  endtask

  task automatic test_operand_stability();
    int acc, rcyc, rise, nrst;
    logic g0, g1, err;
    logic [63:0] res;
    bit moved;
    request(1'b0, OP_MUL, 32'd11, 64'd13, acc);
    req0_opa = 32'd999; req0_opb = 64'd5;
    wait_rsp(rcyc, g0, g1, err, res, rise, nrst, moved);
    checks++;
    if (moved !== 1'b0) begin
      failures++; $display("FAIL stab_opera1_moved got=%b want=0", moved);
    end
    checks++;
    if (mu_opera1 !== 32'd11) begin
      failures++; $display("FAIL stab_opera1_at_resp got=%0d want=11", mu_opera1);
    end
    checks++;
    if ({g0, g1, err, res} !== {3'b100, 64'd143}) begin
      failures++; $display("FAIL stab_result g0/g1/err=%b result=%0d want=100/143", {g0, g1, err}, res);
    end
  endtask

  initial begin
    test_reset();
    test_single_mul();
    test_tie();
    test_div_timeout();
    test_stale_valid();
    test_reset_mid_op();
    test_operand_stability();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
